adres_multictx_pe: RTL and testbench
====================================

// Module: adres_multictx_pe
// PURPOSE
//  Parametrised, pipelined ADRES processing element for CGRA arrays. Stores CONTEXTS configuration
//  words in one serial config chain and steps through them cyclically (modulo schedule) while running.
//  Adds a registered output, a local register file (RF) and N_IN generic inputs. Chains with
//  neighbouring tiles through ConfigIn/ConfigOut.
// PARAMETERS
//  WIDTH     32  datapath width (>=2)
//  N_IN      6   number of neighbour data inputs (>=2)
//  CONTEXTS  4   number of stored context words (>=1)
//  RF_DEPTH  4   local register-file entries (>=2)
//  derived: SEL_W=clog2(N_IN+2), BYP_W=clog2(N_IN), RFA_W=clog2(RF_DEPTH), CTX_W=max(1,clog2(CONTEXTS))
//  derived: CW=4+2*SEL_W+BYP_W+2+2*RFA_W+WIDTH (defaults: 51); L=CONTEXTS*CW (defaults: 204)
// PORTS
//  Config_Clock   in   1           single clock: config chain and datapath
//  Config_Reset   in   1           reset, synchronous, active-low
//  ConfigEnable   in   1           1 = shift config chain one bit/cycle, datapath frozen
//  ConfigIn       in   1           serial config data in
//  ConfigOut      out  1           serial config data out (to next tile)
//  run            in   1           1 = execute current context and advance
//  in_bus         in   N_IN*WIDTH  input k = in_bus[k*WIDTH +: WIDTH]
//  out            out  WIDTH       registered PE result
//  out_valid      out  1           out updated on the previous edge
//  context        out  CTX_W       context index executing this cycle
// BEHAVIOUR
//  Reset (Config_Reset=0 at edge; dominates all): chain, RF, out, out_valid, context <= 0; ConfigOut=0.
//  Config chain: L-bit register; ConfigEnable=1: chain <= {chain[L-2:0], ConfigIn}; ConfigOut = chain[L-1].
//   Context k = chain[k*CW +: CW]. Fields from LSB: func[4], muxa[SEL_W], muxb[SEL_W], byp[BYP_W],
//   outsel[1], rf_we[1], rf_waddr[RFA_W], rf_raddr[RFA_W], const[WIDTH].
//  ConfigEnable=1: context <= 0; out, RF held; out_valid <= 0. ConfigEnable has priority over run.
//  run=1, ConfigEnable=0 (cycle uses word W=context[context]):
//   A = muxa: sel<N_IN -> in k; N_IN -> const; N_IN+1 -> rf[rf_raddr]; else 0.
//   B = muxb: sel<N_IN -> in k; N_IN -> const; N_IN+1 -> out (registered feedback); else 0.
//   BYP = in[byp] if byp<N_IN, else 0.
//   F = func(A,B): 0 add,1 mul(low WIDTH),2 sub A-B,3 unsigned div (B=0 -> all ones),4 and,5 or,6 xor,
//    7 shl,8 ashr,9 lshr (shift amount = B[clog2(WIDTH)-1:0]), 10-15 -> 0. All mod 2^WIDTH.
//   Edge: out <= outsel ? BYP : F; out_valid <= 1; if rf_we: rf[rf_waddr] <= F.
//   context <= (context==CONTEXTS-1) ? 0 : context+1.
//   Latency 1 cycle in->out. RF read is combinational, read-before-write (same-cycle write seen next cycle).
//  run=0, ConfigEnable=0: out, RF, context held; out_valid <= 0.
//  Reset mid-shift or mid-run: partial config discarded; everything restarts from zero.
// TESTING
//  1 Reset mid-config: shift 100 bits, pull Config_Reset low 1 cycle -> ConfigOut=0, out=0, context=0, out_valid=0.
//  2 Chain pass-through: shift 204 bits pattern P -> ConfigOut replays P exactly 204 cycles later; run held 0, out unchanged.
//  3 Rotation: ctx0 add, ctx1 sub, ctx2 xor (muxa=in0, muxb=in1), ctx3 outsel=1 byp=4; in0=10,in1=3,in4=0xAA, run=1
//    -> out=13,7,9,0xAA,13 on successive edges; context 0,1,2,3,0; out_valid=1.
//  4 Accumulator: all ctx add, muxa=7 (RF), muxb=0 (in0=1), rf_we=1, waddr=raddr=0 -> out=1,2,3,4,... ; rf[0] tracks out.
//  5 Edge arithmetic: div 7/0 -> 0xFFFFFFFF; 0xFFFFFFFF+1 -> 0; shl 1 by 33 -> 2; ashr 0x80000000 by 31 -> 0xFFFFFFFF;
//    func 12 -> 0; muxa sel 7 with RF, muxb sel 7 uses out feedback.
//  6 Pause/priority: run=0 for 3 cycles -> out/context held, out_valid=0; ConfigEnable=1 with run=1 -> shift only, context=0.

Source files
------------

// File: rtl/adres_multictx_pe_if.sv
// rtl/adres_multictx_pe_if.sv - config chain and datapath signal bundle for one ADRES PE tile
interface adres_multictx_pe_if #(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 6,
  parameter int CONTEXTS = 4
);
  localparam int CTX_W = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;

  logic                    ConfigEnable;
  logic                    ConfigIn;
  logic                    ConfigOut;
  logic                    run;
  logic [N_IN*WIDTH-1:0]   in_bus;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [CTX_W-1:0]        context_idx;

  modport master (
    output ConfigEnable, ConfigIn, run, in_bus,
    input  ConfigOut, out, out_valid, context_idx
  );

  modport slave (
    input  ConfigEnable, ConfigIn, run, in_bus,
    output ConfigOut, out, out_valid, context_idx
  );
endinterface

// File: rtl/adres_multictx_pe.sv
// rtl/adres_multictx_pe.sv - multi-context ADRES processing element with serial config chain
module adres_multictx_pe #(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 6,
  parameter int CONTEXTS = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic                     Config_Clock,
  input  logic                     Config_Reset,
  adres_multictx_pe_if.slave       bus
);
  localparam int SEL_W = $clog2(N_IN + 2);
  localparam int BYP_W = $clog2(N_IN);
  localparam int RFA_W = $clog2(RF_DEPTH);
  localparam int CTX_W = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CW    = 4 + 2*SEL_W + BYP_W + 2 + 2*RFA_W + WIDTH;
  localparam int L     = CONTEXTS * CW;

  localparam int O_MUXA   = 4;
  localparam int O_MUXB   = O_MUXA + SEL_W;
  localparam int O_BYP    = O_MUXB + SEL_W;
  localparam int O_OUTSEL = O_BYP + BYP_W;
  localparam int O_WE     = O_OUTSEL + 1;
  localparam int O_WADDR  = O_WE + 1;
  localparam int O_RADDR  = O_WADDR + RFA_W;
  localparam int O_CONST  = O_RADDR + RFA_W;

  logic [L-1:0]       chain;
  logic [WIDTH-1:0]   out_q;
  logic               valid_q;
  logic [CTX_W-1:0]   ctx_q;
  logic [WIDTH-1:0]   rf [RF_DEPTH];

  logic [CW-1:0]      word;
  logic [3:0]         func;
  logic [SEL_W-1:0]   muxa, muxb;
  logic [BYP_W-1:0]   byp;
  logic               outsel, rf_we;
  logic [RFA_W-1:0]   rf_waddr, rf_raddr;
  logic [WIDTH-1:0]   cst;
  logic [WIDTH-1:0]   op_a, op_b, byp_val, f;
  logic [SH_W-1:0]    shamt;

  // Select the active context word out of the flat chain.
  always_comb begin
    word = '0;
    for (int k = 0; k < CONTEXTS; k++)
      if (ctx_q == CTX_W'(k)) word = chain[k*CW +: CW];
  end

  assign func     = word[3:0];
  assign muxa     = word[O_MUXA +: SEL_W];
  assign muxb     = word[O_MUXB +: SEL_W];
  assign byp      = word[O_BYP +: BYP_W];
  assign outsel   = word[O_OUTSEL];
  assign rf_we    = word[O_WE];
  assign rf_waddr = word[O_WADDR +: RFA_W];
  assign rf_raddr = word[O_RADDR +: RFA_W];
  assign cst      = word[O_CONST +: WIDTH];

  always_comb begin
    op_a    = '0;
    op_b    = '0;
    byp_val = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (muxa == SEL_W'(k)) op_a = bus.in_bus[k*WIDTH +: WIDTH];
      if (muxb == SEL_W'(k)) op_b = bus.in_bus[k*WIDTH +: WIDTH];
      if (byp == BYP_W'(k))  byp_val = bus.in_bus[k*WIDTH +: WIDTH];
    end
    if (muxa == SEL_W'(N_IN))     op_a = cst;
    if (muxa == SEL_W'(N_IN + 1)) op_a = rf[rf_raddr];
    if (muxb == SEL_W'(N_IN))     op_b = cst;
    if (muxb == SEL_W'(N_IN + 1)) op_b = out_q;
  end

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    f = '0;
    case (func)
      4'd0: f = op_a + op_b;
      4'd1: f = op_a * op_b;
      4'd2: f = op_a - op_b;
      4'd3: f = (op_b == '0) ? '1 : op_a / op_b;
      4'd4: f = op_a & op_b;
      4'd5: f = op_a | op_b;
      4'd6: f = op_a ^ op_b;
      4'd7: f = op_a << shamt;
      4'd8: f = $signed(op_a) >>> shamt;
      4'd9: f = op_a >> shamt;
      default: f = '0;
    endcase
  end

  // Shifting freezes the datapath; RF is written from F even when the output bypasses.
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      chain   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ctx_q   <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (bus.ConfigEnable) begin
      chain   <= {chain[L-2:0], bus.ConfigIn};
      ctx_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.run) begin
      out_q   <= outsel ? byp_val : f;
      valid_q <= 1'b1;
      if (rf_we) rf[rf_waddr] <= f;
      ctx_q   <= (ctx_q == CTX_W'(CONTEXTS - 1)) ? '0 : ctx_q + 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ConfigOut   = chain[L-1];
  assign bus.out         = out_q;
  assign bus.out_valid   = valid_q;
  assign bus.context_idx = ctx_q;
endmodule

// File: tb/tb_adres_multictx_pe.sv
// tb/tb_adres_multictx_pe.sv - directed self-checking bench for adres_multictx_pe
module tb_adres_multictx_pe;
  localparam int WIDTH = 32, N_IN = 6, CONTEXTS = 4, RF_DEPTH = 4;
  localparam int CW = 51, L = 204;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adres_multictx_pe_if #(.WIDTH(WIDTH), .N_IN(N_IN), .CONTEXTS(CONTEXTS)) bus ();

  adres_multictx_pe #(.WIDTH(WIDTH), .N_IN(N_IN), .CONTEXTS(CONTEXTS), .RF_DEPTH(RF_DEPTH)) dut (
    .Config_Clock (clk),
    .Config_Reset (resetn),
    .bus          (bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field order from LSB: func, muxa, muxb, byp, outsel, rf_we, rf_waddr, rf_raddr, const.
  function automatic logic [CW-1:0] mkw(input logic [3:0] fn, input logic [2:0] ma, input logic [2:0] mb,
                                         input logic [2:0] by, input logic os, input logic we,
                                         input logic [1:0] wa, input logic [1:0] ra, input logic [31:0] c);
    return {c, ra, wa, we, os, by, mb, ma, fn};
  endfunction

  task automatic load_cfg(input logic [L-1:0] v);
    bus.ConfigEnable = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      bus.ConfigIn = v[i];
      tick();
    end
    bus.ConfigEnable = 1'b0;
    bus.ConfigIn = 1'b0;
  endtask

  task automatic set_in(input int k, input logic [31:0] v);
    bus.in_bus[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    bus.ConfigEnable = 1'b0;
    bus.ConfigIn = 1'b0;
    bus.run = 1'b0;
    bus.in_bus = '0;
    resetn = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.ConfigOut !== 1'b0) begin n_fail++; $display("FAIL reset_cfgout got=%b exp=0", bus.ConfigOut); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    n_checks++; if (bus.context_idx !== 2'd0) begin n_fail++; $display("FAIL reset_ctx got=%0d exp=0", bus.context_idx); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_config();
    int ones;
    bus.ConfigEnable = 1'b1;
    bus.ConfigIn = 1'b1;
    repeat (L) tick();
    n_checks++; if (bus.ConfigOut !== 1'b1) begin n_fail++; $display("FAIL midcfg_full got=%b exp=1", bus.ConfigOut); end
    repeat (100) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.ConfigIn = 1'b0;
    n_checks++; if (bus.ConfigOut !== 1'b0) begin n_fail++; $display("FAIL midcfg_cfgout got=%b exp=0", bus.ConfigOut); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL midcfg_out got=%h exp=0", bus.out); end
    n_checks++; if (bus.context_idx !== 2'd0) begin n_fail++; $display("FAIL midcfg_ctx got=%0d exp=0", bus.context_idx); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midcfg_valid got=%b exp=0", bus.out_valid); end
    ones = 0;
    for (int i = 0; i < L; i++) begin
      if (bus.ConfigOut !== 1'b0) ones++;
      tick();
    end
    bus.ConfigEnable = 1'b0;
    n_checks++; if (ones !== 0) begin n_fail++; $display("FAIL midcfg_chain_cleared got=%0d ones exp=0", ones); end
  endtask

  task automatic test_rotation();
    logic [31:0] exp_out [5];
    exp_out = '{32'd13, 32'd7, 32'd9, 32'hAA, 32'd13};
    set_in(0, 32'd10); set_in(1, 32'd3); set_in(4, 32'hAA);
    load_cfg({mkw(4'd0, 3'd0, 3'd1, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0),
              mkw(4'd6, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0),
              mkw(4'd2, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0),
              mkw(4'd0, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0)});
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rot_valid_after_cfg got=%b exp=0", bus.out_valid); end
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.context_idx !== 2'(i % 4)) begin n_fail++; $display("FAIL rot_ctx[%0d] got=%0d exp=%0d", i, bus.context_idx, i % 4); end
      tick();
      n_checks++; if (bus.out !== exp_out[i]) begin n_fail++; $display("FAIL rot_out[%0d] got=%h exp=%h", i, bus.out, exp_out[i]); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid[%0d] got=%b exp=1", i, bus.out_valid); end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_accumulator();
    logic [CW-1:0] w;
    w = mkw(4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0);
    set_in(0, 32'd1);
    load_cfg({w, w, w, w});
    bus.run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++; if (bus.out !== 32'(i)) begin n_fail++; $display("FAIL acc_out[%0d] got=%0d exp=%0d", i, bus.out, i); end
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    logic [L-1:0] p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.ConfigEnable = 1'b1;
    for (int i = 0; i < L; i++) begin
      bus.ConfigIn = p[i];
      tick();
    end
    for (int i = 0; i < L; i++) begin
      n_checks++; if (bus.ConfigOut !== p[i]) begin n_fail++; $display("FAIL pass_bit[%0d] got=%b exp=%b", i, bus.ConfigOut, p[i]); end
      bus.ConfigIn = 1'b0;
      tick();
    end
    bus.ConfigEnable = 1'b0;
    n_checks++; if (bus.out !== 32'd6) begin n_fail++; $display("FAIL pass_out_held got=%0d exp=6", bus.out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_edge_arith();
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    exp1 = '{32'hFFFF_FFFF, 32'h0, 32'h2, 32'hFFFF_FFFF};
    exp2 = '{32'h0, 32'd5, 32'd10, 32'd1023};
    set_in(0, 32'd7); set_in(1, 32'd0); set_in(2, 32'hFFFF_FFFF);
    set_in(3, 32'd33); set_in(4, 32'h8000_0000); set_in(5, 32'd31);
    load_cfg({mkw(4'd8, 3'd4, 3'd5, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0),
              mkw(4'd7, 3'd6, 3'd3, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1),
              mkw(4'd0, 3'd2, 3'd6, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1),
              mkw(4'd3, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0)});
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.out !== exp1[i]) begin n_fail++; $display("FAIL edge1_out[%0d] got=%h exp=%h", i, bus.out, exp1[i]); end
    end
    bus.run = 1'b0;
    load_cfg({mkw(4'd1, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0),
              mkw(4'd0, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0),
              mkw(4'd0, 3'd6, 3'd7, 3'd0, 1'b0, 1'b1, 2'd1, 2'd0, 32'd5),
              mkw(4'd12, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0)});
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.out !== exp2[i]) begin n_fail++; $display("FAIL edge2_out[%0d] got=%h exp=%h", i, bus.out, exp2[i]); end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_pause_priority();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out !== 32'd1023) begin n_fail++; $display("FAIL pause_out[%0d] got=%0d exp=1023", i, bus.out); end
      n_checks++; if (bus.context_idx !== 2'd0) begin n_fail++; $display("FAIL pause_ctx[%0d] got=%0d exp=0", i, bus.context_idx); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid[%0d] got=%b exp=0", i, bus.out_valid); end
    end
    bus.run = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.out !== 32'd5) begin n_fail++; $display("FAIL resume_out got=%0d exp=5", bus.out); end
    n_checks++; if (bus.context_idx !== 2'd2) begin n_fail++; $display("FAIL resume_ctx got=%0d exp=2", bus.context_idx); end
    bus.ConfigEnable = 1'b1;
    bus.ConfigIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.context_idx !== 2'd0) begin n_fail++; $display("FAIL prio_ctx[%0d] got=%0d exp=0", i, bus.context_idx); end
      n_checks++; if (bus.out !== 32'd5) begin n_fail++; $display("FAIL prio_out[%0d] got=%0d exp=5", i, bus.out); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid[%0d] got=%b exp=0", i, bus.out_valid); end
    end
    bus.ConfigEnable = 1'b0;
    bus.run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_config();
    test_rotation();
    test_accumulator();
    test_passthrough();
    test_edge_arith();
    test_pause_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
